// File: rtl/servant_uart_pkg.sv
// Shared types and default constants for the servant UART receiver.
// Holds the receiver FSM state type and the default baud and FIFO sizing.
package servant_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 139;
    localparam int DEF_FIFO_DEPTH   = 4;

endpackage

// File: rtl/servant_byte_fifo.sv
// First-word fall-through byte FIFO with extra-MSB pointers.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module servant_byte_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic              full,
    output logic              accepted
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              empty;
    logic              do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign accepted = push && (!full || do_pop);
    assign valid    = !empty;
    assign head     = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accepted) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)   rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (accepted) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/servant_uart_rx.sv
// UART 8N1 receiver: 2-flop line synchroniser, mid-bit sampling FSM and a byte FIFO.
// Frames with a low stop bit raise a framing pulse and wait for the line to idle.
module servant_uart_rx
    import servant_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic       i_wb_clk,
    input  logic       i_wb_rst,
    input  logic       i_rx,
    output logic [7:0] o_dat,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    input  logic       i_clr_ovr,
    output logic       o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_sync_p0;
    logic             rx_sync_p1;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             push;
    logic             push_ok;
    logic             frame_err_d;
    logic             frame_err_q;
    logic             overrun_q;
    logic             fifo_full;

    // Stage p0/p1: metastability synchroniser, idles high out of reset.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= i_rx;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            frame_err_q <= frame_err_d;
            if (push && !push_ok) overrun_q <= 1'b1;
            else if (i_clr_ovr)   overrun_q <= 1'b0;
        end
    end

    always_ff @(posedge i_wb_clk) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_sync_p1) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_p1 ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_p1, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_p1) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (rx_sync_p1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    servant_byte_fifo #(
        .DATA_W    (8),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (i_wb_clk),
        .rst      (i_wb_rst),
        .push     (push),
        .push_data(shift_q),
        .pop      (i_ready),
        .head     (o_dat),
        .valid    (o_valid),
        .full     (fifo_full),
        .accepted (push_ok)
    );

    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = (state_q != IDLE);

endmodule
